// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: direct-mapped 2-bit saturating counters plus a tagged BTB,
// looked up combinationally at fetch and trained from resolved-branch feedback.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module bimodal_branch_predictor #(
  parameter int PC_W    = `PC_SIZE,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch_valid,
  input  logic [PC_W-1:0]  i_fetch_pc,
  output logic             o_pc_override,
  output logic             o_predict_taken,
  output logic [PC_W-1:0]  o_target,
  input  logic             i_fb_valid,
  input  logic [PC_W-1:0]  i_fb_pc,
  input  logic             i_fb_taken,
  input  logic [PC_W-1:0]  i_fb_target,
  input  logic             i_fb_predict_taken,
  input  logic [PC_W-1:0]  i_fb_predict_target,
  output logic [CNT_W-1:0] o_num_branches,
  output logic [CNT_W-1:0] o_num_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  localparam logic [1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [1:0] CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] CNT_MAX     = 2'b11;
  localparam logic [1:0] CNT_MIN     = 2'b00;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CNT_MAX) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CNT_MIN) ? c : c - 2'b01;
  endfunction

  logic [1:0]       cnt_q    [ENTRIES];
  logic [1:0]       cnt_d    [ENTRIES];
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];

  logic [CNT_W-1:0] num_br_q, num_br_d;
  logic [CNT_W-1:0] num_mp_q, num_mp_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX_W-1:0] fb_idx;
  logic [TAG_W-1:0] fb_tag;
  logic             fb_hit;
  logic             fb_mispredict;

  assign fetch_idx = i_fetch_pc[IDX_W-1:0];
  assign fetch_tag = i_fetch_pc[PC_W-1:IDX_W];
  assign fb_idx    = i_fb_pc[IDX_W-1:0];
  assign fb_tag    = i_fb_pc[PC_W-1:IDX_W];

  // Lookup reads only registered state, so a same-cycle train is seen next cycle.
  assign fetch_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign o_predict_taken = !rst && i_fetch_valid && fetch_hit && cnt_q[fetch_idx][1];
  assign o_pc_override   = o_predict_taken;
  assign o_target        = (!rst && fetch_hit) ? target_q[fetch_idx] : '0;

  assign fb_hit        = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
  assign fb_mispredict = (i_fb_predict_taken != i_fb_taken) ||
                         (i_fb_taken && (i_fb_predict_target != i_fb_target));

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (i_fb_valid) begin
      if (i_fb_taken) begin
        valid_d[fb_idx]  = 1'b1;
        tag_d[fb_idx]    = fb_tag;
        target_d[fb_idx] = i_fb_target;
        cnt_d[fb_idx]    = fb_hit ? sat_inc(cnt_q[fb_idx]) : CNT_WEAK_T;
      end else if (fb_hit) begin
        cnt_d[fb_idx] = sat_dec(cnt_q[fb_idx]);
      end
    end
  end

  always_comb begin
    num_br_d = num_br_q;
    num_mp_d = num_mp_q;
    if (i_fb_valid) begin
      if (num_br_q != '1) num_br_d = num_br_q + CNT_W'(1);
      if (fb_mispredict && (num_mp_q != '1)) num_mp_d = num_mp_q + CNT_W'(1);
    end
  end

  // NOTE: only cnt/valid need reset; tag/target are qualified by valid, so they stay reset-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]   <= CNT_WEAK_NT;
        valid_q[i] <= 1'b0;
      end
      num_br_q <= '0;
      num_mp_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      num_br_q <= num_br_d;
      num_mp_q <= num_mp_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign o_num_branches    = num_br_q;
  assign o_num_mispredicts = num_mp_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Self-checking bench for bimodal_branch_predictor: directed scenarios plus a randomized
// run checked against an array-based behavioural model.
module tb_bimodal_branch_predictor;

  localparam int PC_W    = 16;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_LIM = (1 << CNT_W) - 1;
  localparam int S_LIM   = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             i_fetch_valid;
  logic [PC_W-1:0]  i_fetch_pc;
  logic             o_pc_override;
  logic             o_predict_taken;
  logic [PC_W-1:0]  o_target;
  logic             i_fb_valid;
  logic [PC_W-1:0]  i_fb_pc;
  logic             i_fb_taken;
  logic [PC_W-1:0]  i_fb_target;
  logic             i_fb_predict_taken;
  logic [PC_W-1:0]  i_fb_predict_target;
  logic [CNT_W-1:0] o_num_branches;
  logic [CNT_W-1:0] o_num_mispredicts;

  logic             s_fb_valid;
  logic             s_override;
  logic             s_predict;
  logic [PC_W-1:0]  s_target;
  logic [2:0]       s_num_branches;
  logic [2:0]       s_num_mispredicts;

  bimodal_branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .o_pc_override(o_pc_override), .o_predict_taken(o_predict_taken), .o_target(o_target),
    .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_taken(i_fb_taken),
    .i_fb_target(i_fb_target), .i_fb_predict_taken(i_fb_predict_taken),
    .i_fb_predict_target(i_fb_predict_target),
    .o_num_branches(o_num_branches), .o_num_mispredicts(o_num_mispredicts)
  );

  // Narrow-counter instance so saturation at all-ones is reachable in a few cycles.
  bimodal_branch_predictor #(.PC_W(PC_W), .ENTRIES(2), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst),
    .i_fetch_valid(1'b0), .i_fetch_pc(16'h0000),
    .o_pc_override(s_override), .o_predict_taken(s_predict), .o_target(s_target),
    .i_fb_valid(s_fb_valid), .i_fb_pc(16'h0001), .i_fb_taken(1'b0),
    .i_fb_target(16'h0000), .i_fb_predict_taken(1'b1),
    .i_fb_predict_target(16'h0000),
    .o_num_branches(s_num_branches), .o_num_mispredicts(s_num_mispredicts)
  );

  int checks = 0;
  int errors = 0;

  bit m_valid  [ENTRIES];
  int m_tag    [ENTRIES];
  int m_cnt    [ENTRIES];
  int m_target [ENTRIES];
  int m_branches;
  int m_misp;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
      m_tag[i]   = 0;
      m_target[i] = 0;
    end
    m_branches = 0;
    m_misp     = 0;
  endfunction

  function automatic void model_train(input int pc, input bit taken, input int target,
                                      input bit ptaken, input int ptarget);
    int idx;
    int tag;
    bit hit;
    idx = pc % ENTRIES;
    tag = pc / ENTRIES;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (taken) begin
      m_cnt[idx]    = hit ? ((m_cnt[idx] + 1 > 3) ? 3 : m_cnt[idx] + 1) : 2;
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_target[idx] = target;
    end else if (hit) begin
      m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
    end
    if (m_branches < CNT_LIM) m_branches++;
    if (((ptaken != taken) || (taken && (ptarget != target))) && (m_misp < CNT_LIM)) m_misp++;
  endfunction

  function automatic void model_lookup(input bit fv, input int pc, output bit pt, output int tg);
    int idx;
    bit hit;
    idx = pc % ENTRIES;
    hit = m_valid[idx] && (m_tag[idx] == pc / ENTRIES);
    pt  = fv && hit && (m_cnt[idx] >= 2);
    tg  = hit ? m_target[idx] : 0;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    i_fetch_valid = 1'b0;
    i_fb_valid = 1'b0;
    s_fb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_fb(input logic [15:0] pc, input bit taken, input logic [15:0] target,
                       input bit ptaken, input logic [15:0] ptarget);
    i_fb_pc = pc;
    i_fb_taken = taken;
    i_fb_target = target;
    i_fb_predict_taken = ptaken;
    i_fb_predict_target = ptarget;
    i_fb_valid = 1'b1;
    @(posedge clk);
    model_train(int'(pc), taken, int'(target), ptaken, int'(ptarget));
    #1;
    i_fb_valid = 1'b0;
  endtask

  task automatic lookup(input logic [15:0] pc);
    i_fetch_valid = 1'b1;
    i_fetch_pc = pc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_fb_valid = 1'b0;
    s_fb_valid = 1'b0;
    i_fetch_valid = 1'b1;
    i_fetch_pc = 16'h0005;
    @(negedge clk);
    checks++;
    if (o_pc_override !== 1'b0 || o_predict_taken !== 1'b0 || o_target !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: override=%b predict=%b target=%h required 0 0 0000",
               o_pc_override, o_predict_taken, o_target);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    lookup(16'h0005);
    checks++;
    if (o_pc_override !== 1'b0 || o_predict_taken !== 1'b0 ||
        o_num_branches !== 16'd0 || o_num_mispredicts !== 16'd0) begin
      errors++;
      $display("FAIL post_reset: override=%b predict=%b br=%0d mp=%0d required 0 0 0 0",
               o_pc_override, o_predict_taken, o_num_branches, o_num_mispredicts);
    end
  endtask

  task automatic test_training();
    apply_reset();
    do_fb(16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0000);
    lookup(16'h0005);
    checks++;
    if (o_pc_override !== 1'b1 || o_predict_taken !== 1'b1 || o_target !== 16'h0040) begin
      errors++;
      $display("FAIL train_taken: override=%b predict=%b target=%h required 1 1 0040",
               o_pc_override, o_predict_taken, o_target);
    end
    do_fb(16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040);
    do_fb(16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000);
    lookup(16'h0005);
    checks++;
    if (o_pc_override !== 1'b0 || o_target !== 16'h0040) begin
      errors++;
      $display("FAIL train_not_taken: override=%b target=%h required 0 0040",
               o_pc_override, o_target);
    end
    i_fetch_valid = 1'b0;
    do_fb(16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0000);
    do_fb(16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0000);
    @(negedge clk);
    checks++;
    if (o_pc_override !== 1'b0 || o_predict_taken !== 1'b0) begin
      errors++;
      $display("FAIL fetch_invalid: override=%b predict=%b required 0 0",
               o_pc_override, o_predict_taken);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    repeat (5) do_fb(16'h0003, 1'b1, 16'h0030, 1'b1, 16'h0030);
    lookup(16'h0003);
    checks++;
    if (o_pc_override !== 1'b1) begin
      errors++;
      $display("FAIL sat_five_taken: override=%b required 1", o_pc_override);
    end
    do_fb(16'h0003, 1'b0, 16'h0000, 1'b1, 16'h0030);
    lookup(16'h0003);
    checks++;
    if (o_pc_override !== 1'b1) begin
      errors++;
      $display("FAIL sat_one_not_taken: override=%b required 1", o_pc_override);
    end
    do_fb(16'h0003, 1'b0, 16'h0000, 1'b1, 16'h0030);
    lookup(16'h0003);
    checks++;
    if (o_pc_override !== 1'b0) begin
      errors++;
      $display("FAIL sat_two_not_taken: override=%b required 0", o_pc_override);
    end
  endtask

  task automatic test_alias();
    apply_reset();
    do_fb(16'h0013, 1'b1, 16'h0080, 1'b0, 16'h0000);
    lookup(16'h0003);
    checks++;
    if (o_pc_override !== 1'b0 || o_target !== 16'h0000) begin
      errors++;
      $display("FAIL alias_miss: override=%b target=%h required 0 0000", o_pc_override, o_target);
    end
    do_fb(16'h0003, 1'b1, 16'h0020, 1'b0, 16'h0000);
    lookup(16'h0013);
    checks++;
    if (o_pc_override !== 1'b0 || o_target !== 16'h0000) begin
      errors++;
      $display("FAIL alias_evicted: override=%b target=%h required 0 0000", o_pc_override, o_target);
    end
    lookup(16'h0003);
    checks++;
    if (o_pc_override !== 1'b1 || o_target !== 16'h0020) begin
      errors++;
      $display("FAIL alias_replaced: override=%b target=%h required 1 0020", o_pc_override, o_target);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    i_fetch_valid = 1'b1;
    i_fetch_pc = 16'h0007;
    i_fb_pc = 16'h0007;
    i_fb_taken = 1'b1;
    i_fb_target = 16'h0070;
    i_fb_predict_taken = 1'b0;
    i_fb_predict_target = 16'h0000;
    i_fb_valid = 1'b1;
    #1;
    checks++;
    if (o_pc_override !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_pre: override=%b required 0", o_pc_override);
    end
    @(posedge clk);
    #1;
    i_fb_valid = 1'b0;
    checks++;
    if (o_pc_override !== 1'b1 || o_target !== 16'h0070) begin
      errors++;
      $display("FAIL same_cycle_post: override=%b target=%h required 1 0070", o_pc_override, o_target);
    end
  endtask

  task automatic test_counters();
    apply_reset();
    do_fb(16'h0021, 1'b0, 16'h0000, 1'b0, 16'h0000);
    do_fb(16'h0022, 1'b1, 16'h0010, 1'b0, 16'h0000);
    do_fb(16'h0023, 1'b1, 16'h0010, 1'b1, 16'h0020);
    checks++;
    if (o_num_branches !== 16'd3 || o_num_mispredicts !== 16'd2) begin
      errors++;
      $display("FAIL perf_counts: br=%0d mp=%0d required 3 2", o_num_branches, o_num_mispredicts);
    end
  endtask

  task automatic test_counter_saturation();
    int n;
    apply_reset();
    n = 0;
    s_fb_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      n++;
      #1;
      checks++;
      if (int'(s_num_branches) != ((n > S_LIM) ? S_LIM : n) ||
          int'(s_num_mispredicts) != ((n > S_LIM) ? S_LIM : n)) begin
        errors++;
        $display("FAIL perf_saturate: edge %0d br=%0d mp=%0d required %0d",
                 n, s_num_branches, s_num_mispredicts, (n > S_LIM) ? S_LIM : n);
      end
    end
    s_fb_valid = 1'b0;
    checks++;
    if (s_override !== 1'b0 || s_predict !== 1'b0 || s_target !== 16'h0000) begin
      errors++;
      $display("FAIL small_lookup: override=%b predict=%b target=%h required 0 0 0000",
               s_override, s_predict, s_target);
    end
  endtask

  task automatic test_random();
    bit   exp_pt;
    int   exp_tg;
    bit   fb_v;
    int   fb_pc;
    bit   fb_t;
    int   fb_tg;
    bit   fb_pt;
    int   fb_ptg;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      i_fetch_valid = ($urandom_range(0, 3) != 0);
      i_fetch_pc = 16'($urandom_range(0, 3) * ENTRIES + $urandom_range(0, ENTRIES - 1));
      fb_v  = ($urandom_range(0, 2) != 0);
      fb_pc = $urandom_range(0, 3) * ENTRIES + $urandom_range(0, ENTRIES - 1);
      fb_t  = $urandom_range(0, 1);
      fb_tg = (fb_pc * 4 + $urandom_range(0, 1)) & 16'hFFFF;
      model_lookup(1'b1, fb_pc, fb_pt, fb_ptg);
      if ($urandom_range(0, 3) == 0) begin
        fb_pt  = $urandom_range(0, 1);
        fb_ptg = $urandom_range(0, 16'hFFFF);
      end
      i_fb_valid = fb_v;
      i_fb_pc = 16'(fb_pc);
      i_fb_taken = fb_t;
      i_fb_target = 16'(fb_tg);
      i_fb_predict_taken = fb_pt;
      i_fb_predict_target = 16'(fb_ptg);
      #1;
      model_lookup(i_fetch_valid, int'(i_fetch_pc), exp_pt, exp_tg);
      checks++;
      if (o_pc_override !== exp_pt || o_predict_taken !== exp_pt || o_target !== 16'(exp_tg) ||
          int'(o_num_branches) != m_branches || int'(o_num_mispredicts) != m_misp) begin
        errors++;
        $display("FAIL random cyc %0d pc=%h: ov=%b pt=%b tg=%h br=%0d mp=%0d required %b %b %h %0d %0d",
                 cyc, i_fetch_pc, o_pc_override, o_predict_taken, o_target, o_num_branches,
                 o_num_mispredicts, exp_pt, exp_pt, 16'(exp_tg), m_branches, m_misp);
      end
      @(posedge clk);
      if (fb_v) model_train(fb_pc, fb_t, fb_tg, fb_pt, fb_ptg);
    end
    #1;
    i_fb_valid = 1'b0;
    i_fetch_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_fb(16'h0009, 1'b1, 16'h0090, 1'b0, 16'h0000);
    lookup(16'h0009);
    checks++;
    if (o_pc_override !== 1'b1 || o_num_branches !== 16'd1) begin
      errors++;
      $display("FAIL async_setup: override=%b br=%0d required 1 1", o_pc_override, o_num_branches);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_pc_override !== 1'b0 || o_predict_taken !== 1'b0 || o_target !== 16'h0000 ||
        o_num_branches !== 16'd0 || o_num_mispredicts !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: ov=%b pt=%b tg=%h br=%0d mp=%0d required 0 0 0000 0 0",
               o_pc_override, o_predict_taken, o_target, o_num_branches, o_num_mispredicts);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (o_pc_override !== 1'b0 || o_target !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_cleared: override=%b target=%h required 0 0000",
               o_pc_override, o_target);
    end
  endtask

  initial begin
    i_fetch_valid = 1'b0;
    i_fetch_pc = '0;
    i_fb_valid = 1'b0;
    i_fb_pc = '0;
    i_fb_taken = 1'b0;
    i_fb_target = '0;
    i_fb_predict_taken = 1'b0;
    i_fb_predict_target = '0;
    s_fb_valid = 1'b0;
    model_reset();
    test_reset();
    test_training();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_counters();
    test_counter_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
